// File: rtl/byte_serial_dual_port_mem_pkg.sv
// Shared definitions for the byte-serial dual-port data memory.
// This file holds the per-port FSM encoding and the beat-to-lane mapping.
package byte_serial_dual_port_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } port_state_e;

   // Wide enough to hold a beat index for every legal word size (up to 8 bytes).
   localparam int CNT_W = 4;

   // Word lane touched by a given beat; both ports must agree on this mapping.
   function automatic logic [CNT_W-1:0] lane_of(input logic [CNT_W-1:0] beat,
                                                input int               bytes,
                                                input bit               big_endian);
      logic [CNT_W-1:0] lane;
      if (big_endian) begin
         lane = CNT_W'(bytes - 1) - beat;
      end else begin
         lane = beat;
      end
      return lane;
   endfunction

endpackage

// File: rtl/byte_serial_dual_port_mem_port.sv
// One port of the serialised memory: accepts a word request, walks it across
// the byte RAM one beat per cycle and reassembles read data lane by lane.
module byte_serial_dual_port_mem_port
   import byte_serial_dual_port_mem_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int BYTES      = 4,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req,
   output logic                ready,
   input  logic [ADDR_W-1:0]   addr,
   input  logic                we,
   input  logic [8*BYTES-1:0]  wdata,
   input  logic [BYTES-1:0]    be,
   output logic [8*BYTES-1:0]  rdata,
   output logic                done,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic                ram_we,
   output logic [7:0]          ram_din,
   input  logic [7:0]          ram_dout
);

   localparam int W = 8 * BYTES;

   port_state_e       state_q, state_d;
   logic [CNT_W-1:0]  beat_q, beat_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [W-1:0]      wdata_q, wdata_d;
   logic [BYTES-1:0]  be_q, be_d;
   logic              cap_q, cap_d;
   logic [CNT_W-1:0]  cap_lane_q, cap_lane_d;
   logic [W-1:0]      rdata_q, rdata_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;

   logic              accept_s;
   logic              last_beat_s;
   logic [CNT_W-1:0]  lane_s;
   logic [W-1:0]      wdata_sh_s;
   logic [BYTES-1:0]  be_sh_s;
   logic [CNT_W+2:0]  cap_sh_s;

   assign accept_s    = req && ready_q;
   assign last_beat_s = (beat_q == CNT_W'(BYTES - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; the DONE cycle may chain straight into a new access.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = accept_s ? ST_BEAT : ST_IDLE;
         ST_BEAT:  state_d = last_beat_s ? ST_DRAIN : ST_BEAT;
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = accept_s ? ST_BEAT : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Request latching, RAM beat drive and read-data lane capture.
   always_comb begin
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      beat_d     = beat_q;
      lane_s     = lane_of(beat_q, BYTES, BIG_ENDIAN);
      wdata_sh_s = wdata_q >> {lane_s, 3'b000};
      be_sh_s    = be_q >> lane_s;
      cap_sh_s   = {cap_lane_q, 3'b000};
      if (accept_s) begin
         addr_d  = addr;
         we_d    = we;
         wdata_d = wdata;
         be_d    = be;
         beat_d  = '0;
      end else if (state_q == ST_BEAT) begin
         beat_d = beat_q + CNT_W'(1);
      end else begin
         beat_d = beat_q;
      end
      // Address arithmetic wraps naturally at the top of memory.
      ram_addr = addr_q + ADDR_W'(beat_q);
      ram_din  = wdata_sh_s[7:0];
      ram_we   = (state_q == ST_BEAT) && we_q && be_sh_s[0] && rst_n;
      // The RAM answers one cycle later, so remember which lane to fill.
      cap_d      = (state_q == ST_BEAT) && !we_q;
      cap_lane_d = lane_s;
      if (cap_q) begin
         rdata_d = (rdata_q & ~(W'(8'hFF) << cap_sh_s)) | (W'(ram_dout) << cap_sh_s);
      end else begin
         rdata_d = rdata_q;
      end
      ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
      done_d  = (state_d == ST_DONE);
   end

   // Datapath and handshake output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         be_q       <= '0;
         beat_q     <= '0;
         cap_q      <= 1'b0;
         cap_lane_q <= '0;
         rdata_q    <= '0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         beat_q     <= beat_d;
         cap_q      <= cap_d;
         cap_lane_q <= cap_lane_d;
         rdata_q    <= rdata_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
      end
   end

   assign ready = ready_q;
   assign done  = done_q;
   assign rdata = rdata_q;

endmodule

// File: rtl/byte_serial_dual_port_mem_ram.sv
// Byte-wide true-dual-port RAM with a single clock, read-first behaviour and
// a 1-cycle registered read on each port.
module byte_dual_port_ram #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic              a_we,
   input  logic [7:0]        a_din,
   output logic [7:0]        a_dout,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic              b_we,
   input  logic [7:0]        b_din,
   output logic [7:0]        b_dout
);

   logic [7:0] mem_q [0:(1<<ADDR_W)-1];
   logic [7:0] a_dout_q;
   logic [7:0] b_dout_q;

   // Reads sample the array before this edge's writes land, giving read-first.
   always_ff @(posedge clk) begin
      if (a_we) begin
         mem_q[a_addr] <= a_din;
      end
      if (b_we) begin
         mem_q[b_addr] <= b_din;
      end
      a_dout_q <= mem_q[a_addr];
      b_dout_q <= mem_q[b_addr];
   end

   assign a_dout = a_dout_q;
   assign b_dout = b_dout_q;

endmodule

// File: rtl/byte_serial_dual_port_mem.sv
// Word-access data memory on a byte-wide dual-port RAM: port A reads only,
// port B reads or writes with byte enables; each port serialises its word.
module byte_serial_dual_port_mem #(
   parameter int ADDR_W     = 16,
   parameter int BYTES      = 4,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                aReq,
   output logic                aReady,
   input  logic [ADDR_W-1:0]   aAddr,
   output logic [8*BYTES-1:0]  aRdata,
   output logic                aDone,
   input  logic                bReq,
   output logic                bReady,
   input  logic                bWe,
   input  logic [ADDR_W-1:0]   bAddr,
   input  logic [8*BYTES-1:0]  bWdata,
   input  logic [BYTES-1:0]    bBe,
   output logic [8*BYTES-1:0]  bRdata,
   output logic                bDone
);

   logic [ADDR_W-1:0] ram_a_addr_s, ram_b_addr_s;
   logic              ram_a_we_s, ram_b_we_s;
   logic [7:0]        ram_a_din_s, ram_b_din_s;
   logic [7:0]        ram_a_dout_s, ram_b_dout_s;

   byte_serial_dual_port_mem_port #(
      .ADDR_W(ADDR_W), .BYTES(BYTES), .BIG_ENDIAN(BIG_ENDIAN)
   ) u_port_a (
      .clk(clk), .rst_n(rst_n),
      .req(aReq), .ready(aReady), .addr(aAddr),
      .we(1'b0), .wdata({(8*BYTES){1'b0}}), .be({BYTES{1'b0}}),
      .rdata(aRdata), .done(aDone),
      .ram_addr(ram_a_addr_s), .ram_we(ram_a_we_s),
      .ram_din(ram_a_din_s), .ram_dout(ram_a_dout_s)
   );

   byte_serial_dual_port_mem_port #(
      .ADDR_W(ADDR_W), .BYTES(BYTES), .BIG_ENDIAN(BIG_ENDIAN)
   ) u_port_b (
      .clk(clk), .rst_n(rst_n),
      .req(bReq), .ready(bReady), .addr(bAddr),
      .we(bWe), .wdata(bWdata), .be(bBe),
      .rdata(bRdata), .done(bDone),
      .ram_addr(ram_b_addr_s), .ram_we(ram_b_we_s),
      .ram_din(ram_b_din_s), .ram_dout(ram_b_dout_s)
   );

   byte_dual_port_ram #(
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk(clk),
      .a_addr(ram_a_addr_s), .a_we(ram_a_we_s), .a_din(ram_a_din_s), .a_dout(ram_a_dout_s),
      .b_addr(ram_b_addr_s), .b_we(ram_b_we_s), .b_din(ram_b_din_s), .b_dout(ram_b_dout_s)
   );

endmodule
